drum_cmd_arbiter: RTL and testbench

Collects drum-hit requests from several trigger sources (per-IMU stick detectors, kick button), applies per-source retrigger holdoff, arbitrates them round-robin into a command FIFO, and presents one 8-bit drum command at a time to the MCU SPI slave using the DONE/LOAD handshake. It sits between the trigger detectors and the SPI shift register in the integrated drum-trigger top level. It is the only block that drives the MCU-facing DONE line.

---
 rtl/drum_cmd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_drum_cmd_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_cmd_arbiter.sv
// Drum-hit command arbiter: per-source holdoff capture, round-robin grant into a
// command FIFO, and a DONE/LOAD handshake towards the MCU SPI slave.
module drum_cmd_arbiter #(
    parameter int NUM_SRC        = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLDOFF_CYCLES = 150000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [8*NUM_SRC-1:0]          src_cmd,
    input  logic                          mcu_load,
    output logic [7:0]                    spi_cmd,
    output logic                          spi_cmd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count,
    output logic                          overflow,
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    logic [HW-1:0]      r_holdoff [NUM_SRC];
    logic [7:0]         r_cmd_reg [NUM_SRC];
    logic [NUM_SRC-1:0] r_pending;
    logic [SW-1:0]      r_last_grant;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic               r_load_s1;
    logic               r_load_s2;
    logic               r_load_prev;
    state_t             r_state;
    state_t             w_next;
    logic               r_valid;
    logic [7:0]         r_spi_cmd;
    logic [7:0]         r_drop_count;
    logic               r_overflow;

    logic [NUM_SRC-1:0] w_accept;
    logic [NUM_SRC-1:0] w_drop_src;
    logic [NUM_SRC-1:0] w_grant_oh;
    logic [SW-1:0]      w_grant_idx;
    logic               w_grant_vld;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_load_rise;

    assign w_full      = (r_level == LEVEL_FULL);
    assign w_empty     = (r_level == '0);
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_load_rise = r_load_s2 & ~r_load_prev;

    // A source that is still pending once its holdoff has expired can only be
    // stuck behind a full FIFO, so a new hit on it is counted as lost.
    always_comb begin
        w_accept   = '0;
        w_drop_src = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_req[i] && enable && (r_holdoff[i] == '0) &&
                (src_cmd[8*i +: 8] != 8'h00)) begin
                if (r_pending[i]) w_drop_src[i] = 1'b1;
                else              w_accept[i]   = 1'b1;
            end
        end
    end

    always_comb begin
        int idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_SRC;
            if (!w_grant_vld && !w_full && r_pending[idx]) begin
                w_grant_vld     = 1'b1;
                w_grant_idx     = SW'(idx);
                w_grant_oh[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_holdoff[i] <= '0;
                r_cmd_reg[i] <= 8'h00;
            end
            r_pending    <= '0;
            r_last_grant <= SW'(NUM_SRC - 1);
            r_drop_count <= 8'h00;
            r_overflow   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_accept[i]) begin
                    r_holdoff[i] <= HOLD_LOAD;
                    r_cmd_reg[i] <= src_cmd[8*i +: 8];
                end else if (r_holdoff[i] != '0) begin
                    r_holdoff[i] <= r_holdoff[i] - 1'b1;
                end
            end
            r_pending <= (r_pending & ~w_grant_oh) | w_accept;
            if (w_grant_vld) r_last_grant <= w_grant_idx;
            if (|w_drop_src) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant_vld) r_fifo[r_wr_ptr] <= r_cmd_reg[w_grant_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_grant_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_grant_vld, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Handshake: spi_cmd_valid (DONE) rises with a new spi_cmd and holds it
    // steady; the MCU raises LOAD to take it, DONE drops, and the next command
    // is only offered after LOAD has been seen low again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_s1   <= 1'b0;
            r_load_s2   <= 1'b0;
            r_load_prev <= 1'b0;
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_spi_cmd   <= 8'h00;
        end else begin
            r_load_s1   <= mcu_load;
            r_load_s2   <= r_load_s1;
            r_load_prev <= r_load_s2;
            r_state     <= w_next;
            r_valid     <= (w_next == S_PRESENT);
            if (w_pop) r_spi_cmd <= r_fifo[r_rd_ptr];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (!w_empty)    w_next = S_PRESENT;
            S_PRESENT: if (w_load_rise) w_next = S_ACK;
            S_ACK:     if (!r_load_s2)  w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    assign spi_cmd       = r_spi_cmd;
    assign spi_cmd_valid = r_valid;
    assign fifo_level    = r_level;
    assign drop_count    = r_drop_count;
    assign overflow      = r_overflow;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_drum_cmd_arbiter.sv
// Directed bench for drum_cmd_arbiter: capture latency, round-robin order,
// holdoff edges, FIFO overflow with drop counting, and enable/zero/reset gating.
module tb_drum_cmd_arbiter;

    localparam int NS = 3;
    localparam int FD = 4;
    localparam int HO = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NS-1:0] src_req;
    logic [8*NS-1:0] src_cmd;
    logic          mcu_load;
    logic [7:0]    spi_cmd;
    logic          spi_cmd_valid;
    logic [$clog2(FD):0] fifo_level;
    logic [7:0]    drop_count;
    logic          overflow;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    drum_cmd_arbiter #(
        .NUM_SRC(NS), .FIFO_DEPTH(FD), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .src_req(src_req),
        .src_cmd(src_cmd), .mcu_load(mcu_load), .spi_cmd(spi_cmd),
        .spi_cmd_valid(spi_cmd_valid), .fifo_level(fifo_level),
        .drop_count(drop_count), .overflow(overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; src_req = '0; src_cmd = '0; mcu_load = 1'b0;
        idle(3);
        rst_n = 1'b1; enable = 1'b1;
        idle(1);
    endtask

    // Request is sampled by the first posedge inside this task.
    task automatic pulse(input logic [NS-1:0] mask, input logic [8*NS-1:0] cmds);
        src_req = mask; src_cmd = cmds;
        idle(1);
        src_req = '0;
    endtask

    task automatic read_cmd(output logic [7:0] got, output bit ok);
        ok = 1'b0; got = 8'h00;
        for (int c = 0; c < 60; c++) begin
            if (spi_cmd_valid) begin ok = 1'b1; break; end
            idle(1);
        end
        if (ok) begin
            got = spi_cmd;
            mcu_load = 1'b1; idle(10);
            mcu_load = 1'b0; idle(5);
        end
    endtask

    task automatic drain_and_check(input string name);
        logic [7:0] got, exp;
        bit ok;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            read_cmd(got, ok);
            n_tests++;
            if (!ok || got !== exp) begin
                n_fail++;
                $display("FAIL %s read: got %h (seen=%0d) expected %h", name, got, ok, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; src_req = '0; src_cmd = '0; mcu_load = 1'b0;
        idle(3);
        n_tests++;
        if ({spi_cmd, spi_cmd_valid, fifo_level, drop_count, overflow} !==
            {8'h00, 1'b0, 3'd0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: cmd=%h v=%b lvl=%0d drop=%0d ovf=%b expected all zero",
                     spi_cmd, spi_cmd_valid, fifo_level, drop_count, overflow);
        end
        rst_n = 1'b1; enable = 1'b1; idle(1);
    endtask

    task automatic test_single_kick();
        int cnt;
        do_reset();
        pulse(3'b100, {8'h02, 8'h00, 8'h00});   // sampled at edge t
        n_tests++;
        if (spi_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL kick_t: valid=%b expected 0", spi_cmd_valid); end
        idle(1);                                 // after t+1: pushed
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL kick_t1: valid=%b lvl=%0d expected 0/1", spi_cmd_valid, fifo_level);
        end
        idle(1);                                 // after t+2: presented
        n_tests++;
        if (spi_cmd_valid !== 1'b1 || spi_cmd !== 8'h02 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL kick_t2: valid=%b cmd=%h lvl=%0d expected 1/02/0",
                               spi_cmd_valid, spi_cmd, fifo_level);
        end
        mcu_load = 1'b1;
        cnt = 0;
        while (spi_cmd_valid && cnt < 10) begin idle(1); cnt++; end
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || cnt > 3) begin
            n_fail++; $display("FAIL kick_ack_latency: cycles=%0d valid=%b expected <=3/0", cnt, spi_cmd_valid);
        end
        idle(10 - cnt);
        mcu_load = 1'b0;
        idle(6);
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL kick_after: valid=%b lvl=%0d expected 0/0", spi_cmd_valid, fifo_level);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        pulse(3'b111, {8'h02, 8'h11, 8'h10});
        enable = 1'b0;                           // queued commands must still drain
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h02);
        drain_and_check("round_robin");
        enable = 1'b1;
    endtask

    task automatic test_holdoff();
        do_reset();
        pulse(3'b001, {16'h0, 8'h21});           // edge E
        idle(49); pulse(3'b001, {16'h0, 8'h31}); // E+50, in holdoff
        idle(48); pulse(3'b001, {16'h0, 8'h32}); // E+99, last holdoff cycle
        pulse(3'b001, {16'h0, 8'h22});           // E+100, accepted
        idle(2);
        n_tests++;
        if (fifo_level !== 3'd1 || drop_count !== 8'd0 || spi_cmd !== 8'h21) begin
            n_fail++; $display("FAIL holdoff_state: lvl=%0d drop=%0d cmd=%h expected 1/0/21",
                               fifo_level, drop_count, spi_cmd);
        end
        exp_q.push_back(8'h21); exp_q.push_back(8'h22);
        drain_and_check("holdoff");
        idle(10);
        n_tests++;
        if (spi_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL holdoff_extra: valid=%b expected 0", spi_cmd_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        pulse(3'b111, {8'h43, 8'h42, 8'h41});
        idle(110);
        pulse(3'b111, {8'h46, 8'h45, 8'h44});
        idle(4);
        n_tests++;
        if (fifo_level !== 3'd4 || spi_cmd_valid !== 1'b1 || spi_cmd !== 8'h41) begin
            n_fail++; $display("FAIL ovf_full: lvl=%0d valid=%b cmd=%h expected 4/1/41",
                               fifo_level, spi_cmd_valid, spi_cmd);
        end
        idle(45);
        pulse(3'b100, {8'h47, 16'h0});           // still in holdoff: silent
        idle(2);
        n_tests++;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_in_holdoff: drop=%0d ovf=%b expected 0/0", drop_count, overflow);
        end
        idle(60);
        pulse(3'b100, {8'h48, 16'h0});           // pending, holdoff expired: dropped
        idle(2);
        n_tests++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drop: drop=%0d ovf=%b expected 1/1", drop_count, overflow);
        end
        for (int i = 1; i <= 6; i++) exp_q.push_back(8'h40 + 8'(i));
        drain_and_check("overflow_drain");
        idle(10);
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b1 || drop_count !== 8'd1) begin
            n_fail++; $display("FAIL ovf_after: valid=%b lvl=%0d ovf=%b drop=%0d expected 0/0/1/1",
                               spi_cmd_valid, fifo_level, overflow, drop_count);
        end
    endtask

    task automatic test_gating();
        bit seen;
        do_reset();
        enable = 1'b0;
        pulse(3'b001, {16'h0, 8'h55});
        idle(8);
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL gate_enable: valid=%b lvl=%0d drop=%0d expected 0/0/0",
                               spi_cmd_valid, fifo_level, drop_count);
        end
        enable = 1'b1;
        pulse(3'b010, 24'h0);
        idle(8);
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL gate_zero_cmd: valid=%b drop=%0d expected 0/0", spi_cmd_valid, drop_count);
        end
        pulse(3'b011, {8'h0, 8'h57, 8'h56});
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (spi_cmd_valid) begin seen = 1'b1; break; end
            idle(1);
        end
        n_tests++;
        if (!seen || spi_cmd !== 8'h56) begin
            n_fail++; $display("FAIL gate_present: seen=%0d cmd=%h expected 1/56", seen, spi_cmd);
        end
        rst_n = 1'b0;
        idle(1);
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || fifo_level !== 3'd0 || spi_cmd !== 8'h00) begin
            n_fail++; $display("FAIL gate_reset: valid=%b lvl=%0d cmd=%h expected 0/0/00",
                               spi_cmd_valid, fifo_level, spi_cmd);
        end
        rst_n = 1'b1;
        idle(10);
        n_tests++;
        if (spi_cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL gate_post_reset: valid=%b lvl=%0d expected 0/0", spi_cmd_valid, fifo_level);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single_kick();
        test_round_robin();
        test_holdoff();
        test_overflow();
        test_gating();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
